multiport_mem_ctrl: RTL and testbench
=====================================

// Module: multiport_mem_ctrl
// PURPOSE
//  Parametrised backing-store controller for N cache requestors (I-cache, D-cache, page walker, ...).
//  Arbitrates line-sized read/write requests, models a fixed-latency main memory array and returns
//  one-cycle read-ready / write-ack pulses per port. Sits below the fetch and mem stages, outside the core pipeline.
//  Adds over the two-port controller: N ports, selectable round-robin or fixed priority, configurable latency/depth.
// PARAMETERS
//  N_PORTS      2    number of requestor ports (>=1)
//  ADDR_W       20   line address width per port
//  LINE_W       128  line (data) width in bits
//  DEPTH        4096 lines in memory array; power of 2; IDX_W = clog2(DEPTH) <= ADDR_W
//  MEM_LATENCY  5    cycles in BUSY per access (>=1)
//  PRIO_MODE    0    0 = round-robin, 1 = fixed priority (lowest index wins)
// PORTS
//  clk      in   1                 clock, rising edge
//  reset    in   1                 reset, asynchronous, active-low (0 = reset asserted)
//  req      in   N_PORTS           per-port request, held high until that port's ack
//  we       in   N_PORTS           per-port 1 = write, 0 = read; sampled with req at grant
//  addr     in   N_PORTS*ADDR_W    per-port line address, port p at [p*ADDR_W +: ADDR_W]
//  wdata    in   N_PORTS*LINE_W    per-port write line, port p at [p*LINE_W +: LINE_W]
//  rdata    out  LINE_W            read line, shared by all ports
//  rvalid   out  N_PORTS           one-cycle read-ready pulse for the granted port
//  wack     out  N_PORTS           one-cycle write-ack pulse for the granted port
//  grant    out  N_PORTS           one-hot owner of the current transaction; 0 when idle
//  busy     out  1                 1 while a transaction is in BUSY or RESP
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; rdata, rvalid, wack, grant, busy = 0; RR pointer = 0.
//    Memory array is not reset. Reset mid-transaction aborts it: no ack, no array write.
//  - All outputs registered. FSM states IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE, any req high:
//    - select port g: PRIO_MODE=1 lowest index; PRIO_MODE=0 first requesting index at or after the RR pointer, wrapping.
//    - latch we[g], addr[g], wdata[g]; grant = 1<<g; busy = 1; cnt = MEM_LATENCY-1; -> BUSY.
//    - RR pointer = (g+1) mod N_PORTS.
//  - IDLE, no req: stay; grant = 0, busy = 0.
//  - BUSY: cnt==0 -> perform access, -> RESP; else cnt--.
//    - write: mem[idx] = latched wdata. read: rdata = mem[idx].
//    - idx = latched addr[IDX_W-1:0]; upper address bits ignored (aliasing wrap).
//  - RESP, one cycle only: rvalid[g]=1 (read) or wack[g]=1 (write); busy=1; -> IDLE with grant=0, busy=0.
//  - Latency: grant edge at k; ack high during the cycle after edge k+MEM_LATENCY.
//    Back-to-back service therefore costs MEM_LATENCY+2 cycles per transaction.
//  - Requestors drop req the cycle after seeing their ack; req still high in IDLE is a new request.
//  - req/we/addr/wdata changes after grant are ignored. A req dropped during BUSY still gets its ack pulse.
//  - rdata holds its last read value until the next read completes; writes never change rdata.
//  - Read after write to the same idx returns the written line.
//  - Simultaneous reqs are serialised; exactly one grant bit at a time. rvalid|wack has at most one bit set.
// TESTING
//  1. L=5: port0 write addr 0x00005 data {4{32'hA5A5_0001}} -> wack[0] exactly 1 cycle, 5 edges after grant.
//     Then port0 read 0x00005 -> rvalid[0], rdata = {4{32'hA5A5_0001}}.
//  2. N=3, PRIO_MODE=0: req=3'b111 held, each port drops req after its ack and re-raises it next cycle
//     -> grant order 001,010,100,001; no ack to a non-granted port.
//  3. PRIO_MODE=1, req=3'b101 held, port0 re-requesting immediately after each ack -> port0 granted every time, port2 starved.
//     Drop req[0] -> port2 granted next.
//  4. DEPTH=256: write 0x00105 data 128'h1234 -> read 0x00005 returns 128'h1234 (alias wrap).
//  5. Write 0x00010 = 128'hAAAA completes. Start write 0x00010 = 128'hBBBB, pull reset low 2 cycles into BUSY
//     -> no wack, grant=0, busy=0 immediately; after release, read 0x00010 returns 128'hAAAA.
//  6. Port1 read granted, req[1] dropped in BUSY -> rvalid[1] still pulses once, then IDLE, grant=0.

Source files
------------

// File: rtl/multiport_mem_ctrl_if.sv
// Bus between N cache requestors and the shared backing-store controller.
//   req    : per-port request, held until that port's ack
//   we     : per-port write enable (1 = write, 0 = read)
//   addr   : per-port line address, port p at [p*ADDR_W +: ADDR_W]
//   wdata  : per-port write line, port p at [p*LINE_W +: LINE_W]
//   rdata  : read line, shared by all ports
//   rvalid : one-cycle read-ready pulse for the granted port
//   wack   : one-cycle write-ack pulse for the granted port
//   grant  : one-hot owner of the current transaction, 0 when idle
//   busy   : transaction in progress
// The master modport is the requestor side; the slave modport is the controller side.
interface multiport_mem_ctrl_if #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned LINE_W  = 128
) ();
    logic [N_PORTS-1:0]        req;
    logic [N_PORTS-1:0]        we;
    logic [N_PORTS*ADDR_W-1:0] addr;
    logic [N_PORTS*LINE_W-1:0] wdata;
    logic [LINE_W-1:0]         rdata;
    logic [N_PORTS-1:0]        rvalid;
    logic [N_PORTS-1:0]        wack;
    logic [N_PORTS-1:0]        grant;
    logic                      busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, rvalid, wack, grant, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, rvalid, wack, grant, busy
    );
endinterface

// File: rtl/multiport_mem_ctrl.sv
// Backing-store controller for N cache requestors. Arbitrates line-sized read/write requests
// (round-robin or fixed priority), models a fixed-latency memory array and returns one-cycle
// rvalid / wack pulses to the granted port. All outputs are registered.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : slave side of multiport_mem_ctrl_if (req/we/addr/wdata in; rdata/rvalid/wack/grant/busy out)
module multiport_mem_ctrl #(
    parameter int unsigned N_PORTS     = 2,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned MEM_LATENCY = 5,
    parameter int unsigned PRIO_MODE   = 0
) (
    input logic                 clk,
    input logic                 reset,
    multiport_mem_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [N_PORTS-1:0] rvalid_q, rvalid_d;
    logic [N_PORTS-1:0] wack_q, wack_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic               mem_wr;

    logic               sel_valid;
    logic [PTR_W-1:0]   sel_idx;

    logic [LINE_W-1:0]  mem [DEPTH];

    // Upper address bits alias onto the array and are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr;

    // Arbiter. First pass: lowest requesting index at or after the RR pointer (all indices in
    // fixed-priority mode). Second pass wraps around to the lowest requesting index overall.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int p = N_PORTS - 1; p >= 0; p--) begin
            if (bus.req[p] && (PRIO_MODE == 1 || p >= int'(rr_q))) begin
                sel_valid = 1'b1;
                sel_idx   = PTR_W'(p);
            end
        end
        if (!sel_valid) begin
            for (int p = N_PORTS - 1; p >= 0; p--) begin
                if (bus.req[p]) begin
                    sel_valid = 1'b1;
                    sel_idx   = PTR_W'(p);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sel_valid) state_d = StBusy;
            StBusy:  if (cnt_q == '0) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        we_d     = we_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        rvalid_d = '0;
        wack_d   = '0;
        rdata_d  = rdata_q;
        mem_wr   = 1'b0;
        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (sel_valid) begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        grant_d[p] = (sel_idx == PTR_W'(p));
                        if (sel_idx == PTR_W'(p)) begin
                            we_d    = bus.we[p];
                            idx_d   = bus.addr[p*ADDR_W +: IDX_W];
                            wdata_d = bus.wdata[p*LINE_W +: LINE_W];
                        end
                    end
                    busy_d = 1'b1;
                    cnt_d  = CNT_W'(MEM_LATENCY - 1);
                    rr_d   = (sel_idx == PTR_W'(N_PORTS - 1)) ? '0 : sel_idx + 1'b1;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        mem_wr = 1'b1;
                        wack_d = grant_q;
                    end else begin
                        rdata_d  = mem[idx_q];
                        rvalid_d = grant_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            rr_q     <= '0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rvalid_q <= '0;
            wack_q   <= '0;
            rdata_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
            rdata_q  <= rdata_d;
        end
    end

    // Array is not reset; a reset mid-access forces StIdle, so mem_wr is never raised.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.wack   = wack_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_multiport_mem_ctrl.sv
module tb_multiport_mem_ctrl;
    localparam int NP    = 3;
    localparam int AW    = 20;
    localparam int LW    = 128;
    localparam int DP    = 256;
    localparam int LAT_A = 5;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multiport_mem_ctrl_if #(.N_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) ifa ();
    multiport_mem_ctrl_if #(.N_PORTS(NP), .ADDR_W(AW), .LINE_W(LW)) ifb ();

    multiport_mem_ctrl #(
        .N_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .DEPTH(DP), .MEM_LATENCY(LAT_A), .PRIO_MODE(0)
    ) dut_rr (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    multiport_mem_ctrl #(
        .N_PORTS(NP), .ADDR_W(AW), .LINE_W(LW), .DEPTH(DP), .MEM_LATENCY(LAT_B), .PRIO_MODE(1)
    ) dut_prio (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: line store keyed by aliased index, RR pointer, last read line.
    logic [LW-1:0] ref_mem [int];
    int            written[$];
    int            ref_ptr;
    logic [LW-1:0] ref_rdata;

    logic          b_we   [NP];
    logic [AW-1:0] b_addr [NP];
    logic [LW-1:0] b_data [NP];

    function automatic int pick(input logic [NP-1:0] mask);
        for (int i = 0; i < NP; i++) begin
            int p;
            p = (ref_ptr + i) % NP;
            if (mask[p]) begin
                ref_ptr = (p + 1) % NP;
                return p;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        ref_ptr   = 0;
        ref_rdata = '0;
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [LW-1:0] d);
        b_we[p]   = w;
        b_addr[p] = a;
        b_data[p] = d;
        ifa.we[p] = w;
        ifa.addr[p*AW +: AW]  = a;
        ifa.wdata[p*LW +: LW] = d;
    endtask

    // Serves one expected transaction on dut_rr, starting from a negedge with req already raised.
    task automatic serve_one(input int p, input bit drop_early, input bit reraise);
        int            n;
        int            idx;
        logic [NP-1:0] oh;
        logic [NP-1:0] ack;
        oh = '0;
        oh[p] = 1'b1;
        idx = int'(b_addr[p]) % DP;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifa.grant == '0 && n < 20);
        checks++;
        if (ifa.grant !== oh) begin
            failures++;
            $display("FAIL grant: got %b want %b", ifa.grant, oh);
        end
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL grant_delay: got %0d cycles want 1", n);
        end
        checks++;
        if (ifa.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_granted: got %b want 1", ifa.busy);
        end
        if (drop_early) ifa.req[p] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            ack = ifa.rvalid | ifa.wack;
        end while (ack == '0 && n < 20);
        checks++;
        if (n != LAT_A) begin
            failures++;
            $display("FAIL latency: got %0d want %0d", n, LAT_A);
        end
        checks++;
        if (ifa.wack !== (b_we[p] ? oh : '0) || ifa.rvalid !== (b_we[p] ? '0 : oh)) begin
            failures++;
            $display("FAIL ack: wack=%b rvalid=%b want port %0d we=%b", ifa.wack, ifa.rvalid, p,
                     b_we[p]);
        end
        checks++;
        if (ifa.grant !== oh || ifa.busy !== 1'b1) begin
            failures++;
            $display("FAIL resp_state: grant=%b busy=%b want %b/1", ifa.grant, ifa.busy, oh);
        end
        if (b_we[p]) begin
            if (!ref_mem.exists(idx)) written.push_back(idx);
            ref_mem[idx] = b_data[p];
        end else begin
            ref_rdata = ref_mem[idx];
        end
        checks++;
        if (ifa.rdata !== ref_rdata) begin
            failures++;
            $display("FAIL rdata: got %h want %h", ifa.rdata, ref_rdata);
        end
        if (!drop_early) ifa.req[p] = 1'b0;
        @(negedge clk);
        checks++;
        if ((ifa.rvalid | ifa.wack) !== '0 || ifa.grant !== '0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL after_resp: rvalid=%b wack=%b grant=%b busy=%b want all 0",
                     ifa.rvalid, ifa.wack, ifa.grant, ifa.busy);
        end
        if (reraise) ifa.req[p] = 1'b1;
    endtask

    task automatic run_batch(input logic [NP-1:0] mask);
        logic [NP-1:0] pending;
        int p;
        ifa.req = mask;
        pending = mask;
        while (pending != '0) begin
            p = pick(pending);
            pending[p] = 1'b0;
            serve_one(p, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        ifa.req = '0; ifa.we = '0; ifa.addr = '0; ifa.wdata = '0;
        ifb.req = '0; ifb.we = '0; ifb.addr = '0; ifb.wdata = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifa.grant !== '0 || ifa.busy !== 1'b0 || ifa.rvalid !== '0 || ifa.wack !== '0) begin
            failures++;
            $display("FAIL reset_ctrl_a: grant=%b busy=%b rvalid=%b wack=%b want 0",
                     ifa.grant, ifa.busy, ifa.rvalid, ifa.wack);
        end
        checks++;
        if (ifa.rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata_a: got %h want 0", ifa.rdata);
        end
        checks++;
        if (ifb.grant !== '0 || ifb.busy !== 1'b0 || ifb.rvalid !== '0 || ifb.wack !== '0 ||
            ifb.rdata !== '0) begin
            failures++;
            $display("FAIL reset_b: grant=%b busy=%b rvalid=%b wack=%b rdata=%h want 0",
                     ifb.grant, ifb.busy, ifb.rvalid, ifb.wack, ifb.rdata);
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_write_read();
        set_port(0, 1'b1, 20'h00005, {4{32'hA5A5_0001}});
        run_batch(3'b001);
        set_port(0, 1'b0, 20'h00005, '0);
        run_batch(3'b001);
        checks++;
        if (ifa.rdata !== {4{32'hA5A5_0001}}) begin
            failures++;
            $display("FAIL write_read: got %h want %h", ifa.rdata, {4{32'hA5A5_0001}});
        end
    endtask

    task automatic test_round_robin();
        int p;
        for (int i = 0; i < NP; i++) set_port(i, 1'b1, AW'(32'h20 + i), {4{$urandom}});
        ifa.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            p = pick(3'b111);
            serve_one(p, 1'b0, k < 3);
        end
        ifa.req = '0;
    endtask

    task automatic test_priority();
        int            n;
        logic [NP-1:0] exp_oh;
        ifb.we    = 3'b111;
        ifb.addr  = {20'h00003, 20'h00002, 20'h00001};
        ifb.wdata = {$urandom, 352'd0, $urandom};
        ifb.req   = 3'b101;
        for (int k = 0; k < 4; k++) begin
            exp_oh = (k < 3) ? 3'b001 : 3'b100;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ifb.grant == '0 && n < 20);
            checks++;
            if (ifb.grant !== exp_oh) begin
                failures++;
                $display("FAIL prio_grant[%0d]: got %b want %b", k, ifb.grant, exp_oh);
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while ((ifb.wack | ifb.rvalid) == '0 && n < 20);
            checks++;
            if (n != LAT_B || ifb.wack !== exp_oh || ifb.rvalid !== '0) begin
                failures++;
                $display("FAIL prio_ack[%0d]: lat=%0d wack=%b rvalid=%b want %0d/%b/000", k, n,
                         ifb.wack, ifb.rvalid, LAT_B, exp_oh);
            end
            if (k == 2) ifb.req[0] = 1'b0;
            if (k == 3) ifb.req[2] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (ifb.grant !== '0 || ifb.busy !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle: grant=%b busy=%b want 000/0", ifb.grant, ifb.busy);
        end
    endtask

    task automatic test_alias();
        set_port(1, 1'b1, 20'h00105, 128'h1234);
        run_batch(3'b010);
        set_port(2, 1'b0, 20'h00005, '0);
        run_batch(3'b100);
        checks++;
        if (ifa.rdata !== 128'h1234) begin
            failures++;
            $display("FAIL alias: got %h want 1234", ifa.rdata);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        int p;
        set_port(0, 1'b1, 20'h00010, 128'hAAAA);
        run_batch(3'b001);
        set_port(0, 1'b1, 20'h00010, 128'hBBBB);
        ifa.req[0] = 1'b1;
        p = pick(3'b001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifa.grant == '0 && n < 20);
        checks++;
        if (ifa.grant !== 3'b001) begin
            failures++;
            $display("FAIL abort_grant: got %b want 001 (port %0d)", ifa.grant, p);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ifa.grant !== '0 || ifa.busy !== 1'b0 || ifa.wack !== '0 || ifa.rvalid !== '0 ||
            ifa.rdata !== '0) begin
            failures++;
            $display("FAIL abort_async: grant=%b busy=%b wack=%b rvalid=%b rdata=%h want 0",
                     ifa.grant, ifa.busy, ifa.wack, ifa.rvalid, ifa.rdata);
        end
        ifa.req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifa.wack !== '0 || ifa.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold: wack=%b busy=%b want 000/0", ifa.wack, ifa.busy);
        end
        reset = 1'b1;
        model_reset();
        set_port(2, 1'b0, 20'h00010, '0);
        run_batch(3'b100);
        checks++;
        if (ifa.rdata !== 128'hAAAA) begin
            failures++;
            $display("FAIL abort_no_write: got %h want aaaa", ifa.rdata);
        end
    endtask

    task automatic test_drop_in_busy();
        int p;
        set_port(1, 1'b0, 20'h00010, '0);
        ifa.req[1] = 1'b1;
        p = pick(3'b010);
        serve_one(p, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (ifa.grant !== '0 || ifa.rvalid !== '0) begin
            failures++;
            $display("FAIL drop_idle: grant=%b rvalid=%b want 000/000", ifa.grant, ifa.rvalid);
        end
    endtask

    task automatic test_random();
        logic [NP-1:0] mask;
        int            idx;
        for (int it = 0; it < 30; it++) begin
            mask = NP'($urandom_range(1, 7));
            for (int p = 0; p < NP; p++) begin
                if (mask[p]) begin
                    if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
                        set_port(p, 1'b1, AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
                    end else begin
                        idx = written[$urandom_range(0, written.size() - 1)];
                        set_port(p, 1'b0, AW'(($urandom_range(0, 4095) << 8) | idx), '0);
                    end
                end
            end
            run_batch(mask);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_priority();
        test_alias();
        test_reset_abort();
        test_drop_in_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
